tinyqv_qspi_mem_responder: RTL and testbench

// Synthesizable QSPI memory responder: the target end of the tinyQV memory controller's QSPI bus.

---
 rtl/tinyqv_qspi_mem_responder.sv | 190 +++++++++++++++++++
 tb/tb_tinyqv_qspi_mem_responder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/tinyqv_qspi_mem_responder.sv
// QSPI memory responder: decodes quad command/address/data from the tinyQV
// controller and serves reads/writes from a small on-chip byte array.
module tinyqv_qspi_mem_responder #(
  parameter int MEM_BYTES     = 64,
  parameter int DUMMY_NIBBLES = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       spi_select,
  input  logic       spi_clk_in,
  input  logic [3:0] spi_data_in,
  output logic [3:0] spi_data_out,
  output logic [3:0] spi_data_oe,
  output logic       busy
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam logic [7:0] DUMMY_LAST = 8'((DUMMY_NIBBLES > 0) ? DUMMY_NIBBLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_READ, S_WRITE, S_IGNORE
  } state_t;

  state_t          state_q, state_d;
  logic            sck_q;
  logic [7:0]      cnt_q, cnt_d;
  logic [3:0]      cmd_q, cmd_d;
  logic            is_write_q, is_write_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            hi_q, hi_d;
  logic [3:0]      wbuf_q, wbuf_d;
  logic [7:0]      rdata_q, rdata_d;
  logic [3:0]      out_q, out_d;
  logic [3:0]      oe_q, oe_d;
  logic            busy_q, busy_d;

  logic [7:0]      mem [MEM_BYTES];
  logic            mem_we_s;
  logic [7:0]      mem_wdata_s;
  logic            rise_s, fall_s;
  logic [AW-1:0]   addr_shift_s, addr_inc_s;

  assign rise_s       = spi_clk_in & ~sck_q;
  assign fall_s       = ~spi_clk_in & sck_q;
  // Only the low AW address bits are kept; upper nibbles shift out.
  assign addr_shift_s = AW'({addr_q, spi_data_in});
  assign addr_inc_s   = addr_q + AW'(1);

  // Next-state, datapath and output decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    is_write_d  = is_write_q;
    addr_d      = addr_q;
    hi_d        = hi_q;
    wbuf_d      = wbuf_q;
    rdata_d     = rdata_q;
    out_d       = out_q;
    oe_d        = 4'h0;
    mem_we_s    = 1'b0;
    mem_wdata_s = 8'h00;
    if (spi_select) begin
      state_d = S_IDLE;
      cnt_d   = 8'd0;
      hi_d    = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_CMD;
          cnt_d   = 8'd0;
          hi_d    = 1'b1;
        end
        S_CMD: if (rise_s) begin
          cmd_d = spi_data_in;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd1) begin
            cnt_d = 8'd0;
            if ({cmd_q, spi_data_in} == 8'h02) begin
              state_d    = S_ADDR;
              is_write_d = 1'b1;
            end else if ({cmd_q, spi_data_in} == 8'h0B) begin
              state_d    = S_ADDR;
              is_write_d = 1'b0;
            end else begin
              state_d = S_IGNORE;
            end
          end
        end
        S_ADDR: if (rise_s) begin
          addr_d = addr_shift_s;
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == 8'd5) begin
            cnt_d = 8'd0;
            hi_d  = 1'b1;
            if (is_write_q) begin
              state_d = S_WRITE;
            end else if (DUMMY_NIBBLES == 0) begin
              state_d = S_READ;
              rdata_d = mem[addr_shift_s];
            end else begin
              state_d = S_DUMMY;
            end
          end
        end
        S_DUMMY: if (rise_s) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == DUMMY_LAST) begin
            cnt_d   = 8'd0;
            hi_d    = 1'b1;
            state_d = S_READ;
            rdata_d = mem[addr_q];
          end
        end
        S_READ: begin
          oe_d = oe_q;
          if (fall_s) begin
            oe_d = 4'hF;
            if (hi_q) begin
              out_d = rdata_q[7:4];
              hi_d  = 1'b0;
            end else begin
              out_d   = rdata_q[3:0];
              hi_d    = 1'b1;
              addr_d  = addr_inc_s;
              rdata_d = mem[addr_inc_s];
            end
          end
        end
        S_WRITE: if (rise_s) begin
          if (hi_q) begin
            wbuf_d = spi_data_in;
            hi_d   = 1'b0;
          end else begin
            mem_we_s    = 1'b1;
            mem_wdata_s = {wbuf_q, spi_data_in};
            addr_d      = addr_inc_s;
            hi_d        = 1'b1;
          end
        end
        S_IGNORE: state_d = S_IGNORE;
        default:  state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      sck_q      <= 1'b0;
      cnt_q      <= 8'd0;
      cmd_q      <= 4'h0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      hi_q       <= 1'b1;
      wbuf_q     <= 4'h0;
      rdata_q    <= 8'h00;
      out_q      <= 4'h0;
      oe_q       <= 4'h0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sck_q      <= spi_clk_in;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      hi_q       <= hi_d;
      wbuf_q     <= wbuf_d;
      rdata_q    <= rdata_d;
      out_q      <= out_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
    end
  end

  // Byte array survives reset by design
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[addr_q] <= mem_wdata_s;
    end
  end

  assign spi_data_out = out_q;
  assign spi_data_oe  = oe_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_tinyqv_qspi_mem_responder.sv
// Directed + randomized bench for the QSPI memory responder, checked against
// a byte-array model of the memory contents.
module tb_tinyqv_qspi_mem_responder;
  localparam int MB = 64;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       spi_select = 1'b1;
  logic       spi_clk_in = 1'b0;
  logic [3:0] spi_data_in = 4'h0;
  logic [3:0] spi_data_out;
  logic [3:0] spi_data_oe;
  logic       busy;

  int checks = 0;
  int failures = 0;
  logic [7:0] model [MB];

  tinyqv_qspi_mem_responder #(.MEM_BYTES(MB), .DUMMY_NIBBLES(4)) dut (
    .clk(clk), .rstn(rstn), .spi_select(spi_select), .spi_clk_in(spi_clk_in),
    .spi_data_in(spi_data_in), .spi_data_out(spi_data_out),
    .spi_data_oe(spi_data_oe), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCK period (4 clks); outputs sampled just before the rising edge.
  task automatic sck(input logic [3:0] d, output logic [3:0] o, output logic [3:0] e);
    o = spi_data_out;
    e = spi_data_oe;
    spi_data_in = d;
    spi_clk_in = 1'b1;
    tick(2);
    spi_clk_in = 1'b0;
    tick(2);
  endtask

  task automatic send(input logic [3:0] d);
    logic [3:0] o, e;
    sck(d, o, e);
  endtask

  task automatic start(input logic [7:0] cmd, input logic [23:0] a);
    spi_select = 1'b0;
    tick(2);
    check("busy_on_select", {7'h0, busy}, 8'h01);
    send(cmd[7:4]);
    send(cmd[3:0]);
    for (int i = 5; i >= 0; i--) send(a[i*4 +: 4]);
  endtask

  task automatic stop();
    spi_select = 1'b1;
    spi_data_in = 4'h0;
    tick(3);
    check("busy_after_deselect", {7'h0, busy}, 8'h00);
  endtask

  task automatic write_bytes(input logic [23:0] a, input logic [7:0] q[$]);
    start(8'h02, a);
    foreach (q[i]) begin
      send(q[i][7:4]);
      send(q[i][3:0]);
      model[(int'(a % 24'(MB)) + i) % MB] = q[i];
    end
    stop();
  endtask

  task automatic read_dummies(input string tag);
    logic [3:0] o, e;
    for (int i = 0; i < 4; i++) begin
      sck(4'($urandom), o, e);
      if (i == 0) check({tag, "_dummy_oe"}, {4'h0, e}, 8'h00);
    end
  endtask

  task automatic read_check(input string tag, input logic [23:0] a, input int n);
    logic [3:0] o, e;
    logic [7:0] b;
    start(8'h0B, a);
    read_dummies(tag);
    for (int i = 0; i < n; i++) begin
      b = model[(int'(a % 24'(MB)) + i) % MB];
      sck(4'($urandom), o, e);
      check({tag, "_hi"}, {e, o}, {4'hF, b[7:4]});
      sck(4'($urandom), o, e);
      check({tag, "_lo"}, {e, o}, {4'hF, b[3:0]});
    end
    stop();
  endtask

  initial begin
    logic [7:0] q[$];
    logic [3:0] o, e;
    logic [23:0] a;
    int n;

    // Reset
    tick(2);
    check("reset_out_oe", {spi_data_oe, spi_data_out}, 8'h00);
    check("reset_busy", {7'h0, busy}, 8'h00);
    rstn = 1'b1;
    tick(2);

    // Fill whole array so every later read has a known model value
    q = {};
    for (int i = 0; i < MB; i++) q.push_back(8'($urandom));
    write_bytes(24'h000000, q);

    // Directed write then read with dummy cycles
    write_bytes(24'h000010, '{8'hA5, 8'h3C, 8'h7E, 8'h01});
    read_check("wr_rd", 24'h000010, 4);

    // Address wrap at the top of the array
    write_bytes(24'(MB - 1), '{8'h11, 8'h22});
    read_check("wrap_from0", 24'h000000, 1);
    read_check("wrap_fromtop", 24'(MB - 1), 2);

    // Partial write byte must be discarded on deselect
    write_bytes(24'h000004, '{8'h55});
    start(8'h02, 24'h000004);
    send(4'hF);
    stop();
    read_check("abort", 24'h000004, 1);

    // Unknown command: never drives
    spi_select = 1'b0;
    tick(2);
    send(4'h9);
    send(4'hF);
    for (int i = 0; i < 10; i++) begin
      sck(4'($urandom), o, e);
      check("badcmd_oe", {4'h0, e}, 8'h00);
    end
    stop();
    read_check("after_badcmd", 24'h000010, 4);

    // Reset during the third data nibble
    start(8'h0B, 24'h000010);
    read_dummies("rst");
    send(4'h0);
    send(4'h0);
    spi_clk_in = 1'b1;
    tick(1);
    rstn = 1'b0;
    tick(1);
    check("midreset_outs", {spi_data_oe, spi_data_out}, 8'h00);
    check("midreset_busy", {7'h0, busy}, 8'h00);
    spi_clk_in = 1'b0;
    spi_select = 1'b1;
    tick(2);
    rstn = 1'b1;
    tick(2);
    read_check("after_reset", 24'h000010, 4);

    // Randomized bursts with arbitrary upper address bits
    for (int t = 0; t < 12; t++) begin
      a = 24'($urandom);
      n = $urandom_range(1, 6);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      write_bytes(a, q);
      read_check("rand_back", a, n);
      read_check("rand_any", 24'($urandom), $urandom_range(1, 5));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
